// File: rtl/wash_pkg.sv
// Shared types and defaults for the washing-machine sequencer.
//   state_t     : FSM state encoding (IDLE=0 .. FAULT=6)
//   drive_t     : registered actuator drive bundle {valve, shake_mode, turn_mode}
//   state_drive : Moore output decode for a state
//   is_fill     : true for the two tank-filling states
package wash_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FILL_WASH  = 3'd1,
    WASH       = 3'd2,
    FILL_RINSE = 3'd3,
    RINSE      = 3'd4,
    SPIN       = 3'd5,
    FAULT      = 3'd6
  } state_t;

  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_FILL_TIMEOUT = 64;
  localparam int CNT_W            = 16;

  // Lane index of each plant input inside the synchronizer array
  localparam int NUM_IN   = 4;
  localparam int IN_START = 0;
  localparam int IN_FULL  = 1;
  localparam int IN_TIME  = 2;
  localparam int IN_DRY   = 3;

  typedef struct packed {
    logic valve;
    logic shake_mode;
    logic turn_mode;
  } drive_t;

  function automatic drive_t state_drive(state_t s);
    drive_t d;
    d = '0;
    unique case (s)
      FILL_WASH, FILL_RINSE: d.valve      = 1'b1;
      WASH, RINSE:           d.shake_mode = 1'b1;
      SPIN:                  d.turn_mode  = 1'b1;
      default:               d = '0;
    endcase
    return d;
  endfunction

  function automatic logic is_fill(state_t s);
    return (s == FILL_WASH) || (s == FILL_RINSE);
  endfunction

endpackage

// File: rtl/wash_input_sync.sv
// One-lane input synchronizer with rising-edge detector.
//   clock, reset_n : system clock, async active-low reset
//   d              : raw asynchronous input
//   q              : synchronized level (d itself when STAGES == 0)
//   rise           : one-cycle pulse when q goes 0 -> 1
module wash_input_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic          prev;
  // Counts cycles since reset release; q/prev only reflect the real input
  // once the whole chain has refilled, so an input already high at release
  // is not mistaken for an edge.
  logic [STAGES:0] vld_pipe;

  generate
    if (STAGES == 0) begin : g_bypass
      assign q = d;
    end else begin : g_sync
      logic [STAGES-1:0] sr;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sr <= '0;
        else begin
          sr[0] <= d;
          for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
        end
      end
      assign q = sr[STAGES-1];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev     <= 1'b0;
      vld_pipe <= '0;
    end else begin
      prev        <= q;
      vld_pipe[0] <= 1'b1;
      for (int i = 1; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign rise = q & ~prev & vld_pipe[STAGES];

endmodule

// File: rtl/wash_cycle_fsm.sv
// Washing-machine sequencer: fill -> wash -> refill -> rinse -> spin.
//   clock, reset_n : system clock, async active-low reset
//   start          : operator start (rising edge acts in IDLE/FAULT)
//   full           : tank-full level
//   Time           : wash/rinse timer expired (rising edge acts)
//   dry            : load-dry level
//   valve          : inlet valve open (fill states)
//   shake_mode     : agitate motor (wash/rinse)
//   turn_mode      : spin motor (spin)
// Outputs are registered from the next state, so they change on the same
// edge as the state register and are mutually exclusive.
module wash_cycle_fsm
  import wash_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int FILL_TIMEOUT = DEF_FILL_TIMEOUT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  input  logic full,
  input  logic Time,
  input  logic dry,
  output logic valve,
  output logic shake_mode,
  output logic turn_mode
);

  logic [NUM_IN-1:0] raw, lvl, rise;
  logic              unused_rise;

  assign raw[IN_START] = start;
  assign raw[IN_FULL]  = full;
  assign raw[IN_TIME]  = Time;
  assign raw[IN_DRY]   = dry;

  wash_input_sync #(.STAGES(SYNC_STAGES)) u_sync [NUM_IN-1:0] (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (raw),
    .q       (lvl),
    .rise    (rise)
  );

  // full/dry act on level only
  assign unused_rise = rise[IN_FULL] ^ rise[IN_DRY];

  state_t           state, state_nxt;
  logic [CNT_W-1:0] fill_cnt, cnt_inc;

  assign cnt_inc = fill_cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:       if (rise[IN_START]) state_nxt = FILL_WASH;
      // full on the timeout edge still wins
      FILL_WASH:  if (lvl[IN_FULL]) state_nxt = WASH;
                  else if (cnt_inc == CNT_W'(FILL_TIMEOUT)) state_nxt = FAULT;
      WASH:       if (rise[IN_TIME]) state_nxt = FILL_RINSE;
      FILL_RINSE: if (lvl[IN_FULL]) state_nxt = RINSE;
                  else if (cnt_inc == CNT_W'(FILL_TIMEOUT)) state_nxt = FAULT;
      RINSE:      if (rise[IN_TIME]) state_nxt = SPIN;
      SPIN:       if (lvl[IN_DRY]) state_nxt = IDLE;
      FAULT:      if (rise[IN_START]) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      fill_cnt   <= '0;
      valve      <= 1'b0;
      shake_mode <= 1'b0;
      turn_mode  <= 1'b0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= (state_nxt == state && is_fill(state)) ? cnt_inc : '0;
      {valve, shake_mode, turn_mode} <= state_drive(state_nxt);
    end
  end

endmodule

// File: tb/tb_wash_cycle_fsm.sv
module tb_wash_cycle_fsm;

  localparam int SYNC = 2;
  localparam int TO   = 8;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0, full = 1'b0, tmr = 1'b0, dry = 1'b0;
  logic valve, shake_mode, turn_mode;

  int total = 0;
  int bad   = 0;

  wash_cycle_fsm #(.SYNC_STAGES(SYNC), .FILL_TIMEOUT(TO)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .full       (full),
    .Time       (tmr),
    .dry        (dry),
    .valve      (valve),
    .shake_mode (shake_mode),
    .turn_mode  (turn_mode)
  );

  always #5 clock = ~clock;

  // Reference model: the wash program as a table of phases. Each working
  // phase has an exit condition; fills also have a dwell limit.
  // phase: 0 idle, 1 fill, 2 wash, 3 refill, 4 rinse, 5 spin, 6 fault
  // exit kind: 0 tank full, 1 timer edge, 2 load dry
  int          exit_kind [7] = '{0, 0, 1, 0, 1, 2, 0};
  logic [2:0]  drive_tab [7] = '{3'b000, 3'b100, 3'b010, 3'b100, 3'b010, 3'b001, 3'b000};
  logic [3:0]  hist[$];   // sampled {dry,Time,full,start} per edge since release
  int          edges = 0;
  int          ph    = 0;
  int          dwell = 0;
  int          vcnt  = 0;

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock: model the edge, then check on the falling edge.
  task automatic step();
    logic [3:0] s, p;
    logic       ok, st_r, tm_r, cond;
    int         nph;
    @(posedge clock);
    if (reset_n) begin
      hist.push_back({dry, tmr, full, start});
      edges++;
      // a synchronized input lags the pin by SYNC edges
      s  = (edges > SYNC)     ? hist[edges-1-SYNC] : 4'b0;
      p  = (edges > SYNC + 1) ? hist[edges-2-SYNC] : 4'b0;
      ok = (edges >= SYNC + 2);
      st_r = ok & s[0] & ~p[0];
      tm_r = ok & s[2] & ~p[2];
      nph = ph;
      if (ph == 0 || ph == 6) begin
        if (st_r) nph = (ph == 0) ? 1 : 0;
      end else begin
        case (exit_kind[ph])
          0:       cond = s[1];
          1:       cond = tm_r;
          default: cond = s[3];
        endcase
        if (cond) nph = (ph + 1) % 6;
        else if ((ph == 1 || ph == 3) && dwell + 1 == TO) nph = 6;
      end
      dwell = (nph == ph) ? dwell + 1 : 0;
      ph = nph;
    end
    @(negedge clock);
    if (valve) vcnt++;
    check("outputs", {valve, shake_mode, turn_mode}, drive_tab[ph]);
    check("state", 3'(dut.state), 3'(ph));
    check("onehot", {2'b00, ($countones({valve, shake_mode, turn_mode}) <= 1)}, 3'b001);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Async reset mid-cycle: outputs must clear with no clock edge.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    hist.delete();
    edges = 0; ph = 0; dwell = 0;
    check("rst_outputs", {valve, shake_mode, turn_mode}, 3'b000);
    check("rst_state", 3'(dut.state), 3'b000);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    @(negedge clock);
    do_reset();
    run(3);

    // Full program with timely sensors
    start = 1; run(1); start = 0; run(4);
    full = 1; run(4);
    tmr = 1; run(1); tmr = 0; run(5);       // refill with full already high
    tmr = 1; run(1); tmr = 0; run(4);
    dry = 1; run(4); dry = 0; full = 0; run(2);

    // Reset mid-wash, release with start held high
    start = 1; run(1); start = 0; full = 1; run(6);
    check("in_wash", {valve, shake_mode, turn_mode}, 3'b010);
    start = 1;
    do_reset();
    run(6);
    start = 0; run(2); start = 1; run(5); start = 0;
    do_reset();

    // Fill timeout then recovery via two start edges
    full = 0; vcnt = 0;
    start = 1; run(1); start = 0; run(14);
    check("valve_cycles", 3'(vcnt), 3'(TO));
    start = 1; run(1); start = 0; run(4);
    start = 1; run(1); start = 0; run(4);
    do_reset();

    // Time stuck high from wash onward
    full = 1; start = 1; run(1); start = 0; run(5);
    tmr = 1; run(10); tmr = 0; run(2); tmr = 1; run(4); tmr = 0;
    dry = 1; run(3); dry = 0;
    do_reset();

    // Start pulses ignored in wash and spin
    full = 1; start = 1; run(1); start = 0; run(5);
    for (int i = 0; i < 4; i++) begin start = 1; run(2); start = 0; run(2); end
    tmr = 1; run(1); tmr = 0; run(6);
    tmr = 1; run(1); tmr = 0; run(4);
    for (int i = 0; i < 4; i++) begin start = 1; run(2); start = 0; run(2); end
    dry = 1; run(3); dry = 0; full = 0;
    do_reset();

    // Random stimulus with occasional async resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) start = ~start;
      if ($urandom_range(0, 5) == 0) full  = ~full;
      if ($urandom_range(0, 4) == 0) tmr   = ~tmr;
      dry = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 399) == 0) do_reset();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wash_cycle_fsm.md
Name: wash_cycle_fsm

Overview:
Washing-machine sequencing controller. Takes operator start plus plant sensors (tank full, wash timer expired, load dry) and drives the water-inlet valve, the agitate (shake) motor mode and the spin (turn) motor mode. The sequence is fill, wash, refill, rinse, spin. It sits between the sensor/timer front end and the motor/valve drivers. A separate bench-side stimulus model (wash_stimulus) produces the sensor inputs for verification and is not part of the RTL deliverable.

Parameters:
SYNC_STAGES, 2, number of input synchronizer flops on start/full/Time/dry; legal range 0..3; 0 means inputs are used directly.
FILL_TIMEOUT, 64, max clock cycles allowed in a fill state before entering FAULT; legal range 1..65535.

Ports:
clock  input  1  system clock, rising edge active
reset_n  input  1  asynchronous, active-low reset
start  input  1  operator start request; level signal, rising edge acts
full  input  1  tank-full sensor, level
Time  input  1  wash/rinse timer expired; rising edge acts
dry  input  1  spin complete / load dry sensor, level
valve  output  1  water inlet valve open
shake_mode  output  1  agitate motor enable
turn_mode  output  1  spin motor enable

Behaviour:
- One clock; reset is asynchronous and active-low: reset_n low forces state=IDLE, fill counter=0, synchronizers=0, edge-detect history=0, valve=shake_mode=turn_mode=0 immediately.
- Inputs pass through SYNC_STAGES flops. start_rise and time_rise are derived from the synchronized signal versus its previous-cycle value.
- States: IDLE, FILL_WASH, WASH, FILL_RINSE, RINSE, SPIN, FAULT.
- Transitions (evaluated each rising edge on synchronized values):
  - IDLE -> FILL_WASH on start_rise.
  - FILL_WASH -> WASH when full=1.
  - WASH -> FILL_RINSE on time_rise.
  - FILL_RINSE -> RINSE when full=1.
  - RINSE -> SPIN on time_rise.
  - SPIN -> IDLE when dry=1.
  - FILL_WASH/FILL_RINSE -> FAULT when the fill counter reaches FILL_TIMEOUT while full=0; full=1 on the same edge takes priority.
  - FAULT -> IDLE on start_rise.
- Fill counter clears on every state change and increments each cycle in a fill state.
- Registered Moore outputs, updated on the same edge as the state register:
  - valve=1 in FILL_WASH and FILL_RINSE.
  - shake_mode=1 in WASH and RINSE.
  - turn_mode=1 in SPIN.
  - All outputs 0 in IDLE and FAULT.
  - At most one output is high at any time.
- Latency: an input change reaches the outputs after SYNC_STAGES+1 rising edges.
- Every active state lasts at least one cycle. If full is already 1 on entering a fill state, valve is high for exactly 1 cycle.
- start edges outside IDLE/FAULT are ignored. A Time level held high across a state change does not advance the next state; a new rising edge is required.
- Reset asserted mid-cycle aborts immediately to IDLE with outputs 0. After reset release the FSM waits for a fresh start edge. If start is already high at release, no edge is seen until it falls and rises again.

Decomposition:
- Shared package wash_pkg: state enum (3-bit encoding IDLE=0, FILL_WASH=1, WASH=2, FILL_RINSE=3, RINSE=4, SPIN=5, FAULT=6) and default constants for SYNC_STAGES and FILL_TIMEOUT.
- One natural sub-module: wash_input_sync, a parameterized N-stage synchronizer plus rising-edge detector, instantiated for the four inputs.

Test Plan:
- Full cycle, SYNC_STAGES=2:
  - start pulse -> valve=1 3 clocks later.
  - full=1 -> valve=0, shake_mode=1.
  - Time pulse -> shake_mode=0, valve=1.
  - full held -> shake_mode=1 (rinse).
  - Time pulse -> turn_mode=1.
  - dry=1 -> all outputs 0, state IDLE.
- Reset mid-WASH: reset_n=0 while shake_mode=1 -> all outputs 0 with no clock edge. Release with start held high -> remains IDLE until start toggles 0->1.
- Fill timeout, FILL_TIMEOUT=8: start, full kept 0 -> valve high 8 cycles, then FAULT with outputs 0. start edge -> IDLE. A second start edge -> FILL_WASH.
- Time stuck high: hold Time=1 from WASH onward -> exits WASH once, stays in RINSE (shake_mode=1) until Time drops and rises again.
- Ignored starts and exclusivity: repeated start pulses during WASH/SPIN -> no state change. Check every cycle that valve+shake_mode+turn_mode <= 1.
- full already 1 at start: valve asserts for exactly 1 cycle, then shake_mode=1.
